// File: rtl/acc_alu_ctrl.sv
// Datapath core of the 8-bit accumulator CPU: instruction decode, accumulator
// register and ALU. PC, register file, memory and address mux live outside.
module acc_alu_ctrl #(
   parameter int WIDTH = 8,
   parameter int IMM_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] instr,
   input  logic [WIDTH-1:0] reg_rdata,
   input  logic [WIDTH-1:0] pc_addr,
   output logic [IMM_W-1:0] reg_addr,
   output logic             reg_we,
   output logic             reg_wsel,
   output logic             mem_we,
   output logic             mem_sel,
   output logic             branch,
   output logic             branch_taken,
   output logic [1:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] acc_out,
   output logic             acc_nz
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_NAND = 3'b010,
      OP_LI   = 3'b011,
      OP_LA   = 3'b100,
      OP_LW   = 3'b101,
      OP_SW   = 3'b110,
      OP_JAL  = 3'b111
   } op_t;

   op_t              w_op;
   logic [IMM_W-1:0] w_imm;
   logic [WIDTH-1:0] w_ext_imm;
   logic             w_reg_we;
   logic             w_mem_we;
   logic             w_branch;
   logic [WIDTH-1:0] r_acc;

   assign w_op      = op_t'(instr[WIDTH-1 -: 3]);
   assign w_imm     = instr[IMM_W-1:0];
   assign w_ext_imm = {{(WIDTH-IMM_W){w_imm[IMM_W-1]}}, w_imm};

   always_comb begin
      w_reg_we = 1'b0;
      w_mem_we = 1'b0;
      w_branch = 1'b0;
      reg_wsel = 1'b0;
      mem_sel  = 1'b0;
      alu_ctrl = 2'b00;
      case (w_op)
         OP_ADD:  begin w_reg_we = 1'b1; alu_ctrl = 2'b00; end
         OP_SUB:  begin w_reg_we = 1'b1; alu_ctrl = 2'b01; end
         OP_NAND: begin w_reg_we = 1'b1; alu_ctrl = 2'b10; end
         OP_LW:   begin w_reg_we = 1'b1; reg_wsel = 1'b1; mem_sel = 1'b1; end
         OP_SW:   begin w_mem_we = 1'b1; mem_sel = 1'b1; end
         OP_JAL:  begin w_reg_we = 1'b1; w_branch = 1'b1; alu_ctrl = 2'b11; end
         default: ;
      endcase
   end

   // Write/branch strobes are squashed while reset is held so nothing external
   // commits state; the rest stays purely combinational.
   assign reg_addr     = w_imm;
   assign reg_we       = w_reg_we & rst_n;
   assign mem_we       = w_mem_we & rst_n;
   assign branch       = w_branch & rst_n;
   assign branch_taken = w_branch & rst_n & acc_nz;

   always_comb begin
      case (alu_ctrl)
         2'b00:   alu_out = r_acc + reg_rdata;
         2'b01:   alu_out = r_acc - reg_rdata;
         2'b10:   alu_out = ~(r_acc & reg_rdata);
         default: alu_out = pc_addr + WIDTH'(1);
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_acc <= '0;
      else if (w_op == OP_LI)
         r_acc <= w_ext_imm;
      else if (w_op == OP_LA)
         r_acc <= reg_rdata;
   end

   assign acc_out = r_acc;
   assign acc_nz  = |r_acc;

endmodule

// File: tb/tb_acc_alu_ctrl.sv
// Self-checking bench for acc_alu_ctrl: directed literal checks plus randomized
// traffic compared every cycle against an arithmetic model of the CPU core.
module tb_acc_alu_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] instr;
   logic [7:0] reg_rdata;
   logic [7:0] pc_addr;
   logic [4:0] reg_addr;
   logic       reg_we, reg_wsel, mem_we, mem_sel, branch, branch_taken, acc_nz;
   logic [1:0] alu_ctrl;
   logic [7:0] alu_out, acc_out;

   int n_tests = 0;
   int n_fail  = 0;
   int m_acc   = 0;

   acc_alu_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr        (instr),
      .reg_rdata    (reg_rdata),
      .pc_addr      (pc_addr),
      .reg_addr     (reg_addr),
      .reg_we       (reg_we),
      .reg_wsel     (reg_wsel),
      .mem_we       (mem_we),
      .mem_sel      (mem_sel),
      .branch       (branch),
      .branch_taken (branch_taken),
      .alu_ctrl     (alu_ctrl),
      .alu_out      (alu_out),
      .acc_out      (acc_out),
      .acc_nz       (acc_nz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 2 time units after a rising edge, so they are stable at
   // the next falling edge and at the edge that samples them.
   task automatic drive(input logic [7:0] i, input logic [7:0] d,
                        input logic [7:0] p, input logic r);
      @(posedge clk);
      #2;
      instr = i; reg_rdata = d; pc_addr = p; rst_n = r;
   endtask

   task automatic settle();
      #2;
   endtask

   // Model: acc is an integer mod 256; every output is computed from the
   // instruction-set rules directly.
   always @(negedge clk) begin
      int op, imm, a, b, exp_alu, exp_ctrl, ext;
      bit we, wsel, mwe, msel, br;
      op  = instr[7:5];
      imm = instr[4:0];
      a   = m_acc;
      b   = reg_rdata;
      we   = (op == 0 || op == 1 || op == 2 || op == 5 || op == 7);
      wsel = (op == 5);
      mwe  = (op == 6);
      msel = (op == 5 || op == 6);
      br   = (op == 7);
      exp_ctrl = (op == 1) ? 1 : (op == 2) ? 2 : (op == 7) ? 3 : 0;
      case (exp_ctrl)
         0: exp_alu = (a + b) % 256;
         1: exp_alu = (a - b + 256) % 256;
         2: exp_alu = 255 - (a & b);
         default: exp_alu = (pc_addr + 1) % 256;
      endcase
      chk("acc_out", acc_out, a);
      chk("acc_nz", acc_nz, (a != 0) ? 1 : 0);
      chk("reg_addr", reg_addr, imm);
      chk("alu_ctrl", alu_ctrl, exp_ctrl);
      chk("alu_out", alu_out, exp_alu);
      chk("reg_we", reg_we, (we && rst_n) ? 1 : 0);
      chk("reg_wsel", reg_wsel, wsel ? 1 : 0);
      chk("mem_we", mem_we, (mwe && rst_n) ? 1 : 0);
      chk("mem_sel", mem_sel, msel ? 1 : 0);
      chk("branch", branch, (br && rst_n) ? 1 : 0);
      chk("branch_taken", branch_taken, (br && rst_n && a != 0) ? 1 : 0);
      // next accumulator, taken by the upcoming rising edge
      ext = (imm >= 16) ? imm - 32 : imm;
      if (!rst_n)      m_acc = 0;
      else if (op == 3) m_acc = (ext + 256) % 256;
      else if (op == 4) m_acc = b;
   end

   initial begin
      instr = 8'hFF; reg_rdata = 8'h00; pc_addr = 8'h00; rst_n = 1'b0;

      // reset held for two edges with a JAL/BNZ opcode present
      drive(8'hFF, 8'h00, 8'h00, 1'b0);
      settle();
      chk("rst acc", acc_out, 8'h00);
      chk("rst reg_we", reg_we, 0);
      chk("rst mem_we", mem_we, 0);
      chk("rst taken", branch_taken, 0);
      drive(8'h00, 8'h00, 8'h00, 1'b1);
      drive(8'h6F, 8'h00, 8'h00, 1'b1);
      settle();
      chk("release acc", acc_out, 8'h00);

      // LI sign extension, then ADD using the freshly loaded accumulator
      drive(8'h70, 8'h00, 8'h00, 1'b1);
      settle();
      chk("li pos", acc_out, 8'h0F);
      drive(8'h03, 8'h11, 8'h00, 1'b1);
      settle();
      chk("li neg", acc_out, 8'hF0);
      chk("add alu", alu_out, 8'h01);
      chk("add we", reg_we, 1);
      chk("add addr", reg_addr, 3);

      // SUB and NAND wrap
      drive(8'h63, 8'h00, 8'h00, 1'b1);
      drive(8'h21, 8'h05, 8'h00, 1'b1);
      settle();
      chk("sub alu", alu_out, 8'hFE);
      drive(8'h70, 8'h00, 8'h00, 1'b1);
      drive(8'h40, 8'h3C, 8'h00, 1'b1);
      settle();
      chk("nand alu", alu_out, 8'hCF);

      // LA, LW, SW
      drive(8'h80, 8'h2A, 8'h00, 1'b1);
      drive(8'hA0, 8'h00, 8'h00, 1'b1);
      settle();
      chk("la acc", acc_out, 8'h2A);
      chk("lw we", reg_we, 1);
      chk("lw wsel", reg_wsel, 1);
      chk("lw msel", mem_sel, 1);
      chk("lw mwe", mem_we, 0);
      drive(8'hC0, 8'h00, 8'h00, 1'b1);
      settle();
      chk("sw mwe", mem_we, 1);
      chk("sw msel", mem_sel, 1);
      chk("sw we", reg_we, 0);

      // branch / link
      drive(8'h60, 8'h00, 8'h00, 1'b1);
      drive(8'hFE, 8'h00, 8'h20, 1'b1);
      settle();
      chk("jal alu", alu_out, 8'h21);
      chk("jal we", reg_we, 1);
      chk("jal branch", branch, 1);
      chk("jal nt", branch_taken, 0);
      drive(8'h61, 8'h00, 8'h00, 1'b1);
      drive(8'hFE, 8'h00, 8'h20, 1'b1);
      settle();
      chk("jal taken", branch_taken, 1);
      drive(8'hFE, 8'h00, 8'hFF, 1'b1);
      settle();
      chk("link wrap", alu_out, 8'h00);

      // reset asserted while an LA is presented
      drive(8'h65, 8'h00, 8'h00, 1'b1);
      drive(8'h80, 8'h77, 8'h00, 1'b0);
      settle();
      chk("pre-rst acc", acc_out, 8'h05);
      drive(8'hFE, 8'h00, 8'h00, 1'b0);
      settle();
      chk("mid-rst acc", acc_out, 8'h00);
      chk("mid-rst we", reg_we, 0);
      chk("mid-rst taken", branch_taken, 0);
      chk("mid-rst branch", branch, 0);

      // randomized traffic, occasional reset pulses
      for (int k = 0; k < 2000; k++) begin
         drive(8'($urandom), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 15) != 0));
      end
      drive(8'h00, 8'h00, 8'h00, 1'b1);
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/acc_alu_ctrl.md
Name: acc_alu_ctrl

Overview:
- Datapath core of the 8-bit accumulator CPU: instruction decoder, 8-bit accumulator register and 8-bit ALU in one block.
- Each cycle it takes the fetched instruction, the register-file read data and the current PC. It produces register/memory/branch controls, the ALU result and the accumulator value.
- PC, register file, memory and the address mux live outside this block.

Parameters:
- WIDTH, 8, datapath width (accumulator, ALU, register data, PC).
- IMM_W, 5, immediate / register-index field width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- instr  in  8  current instruction: [7:5] opcode, [4:0] imm.
- reg_rdata  in  8  register file data at index imm.
- pc_addr  in  8  current PC, used as the link value.
- reg_addr  out  5  register index, = instr[4:0].
- reg_we  out  1  register file write enable.
- reg_wsel  out  1  register write source: 0 = alu_out, 1 = memory data.
- mem_we  out  1  memory write enable.
- mem_sel  out  1  memory address source: 0 = PC, 1 = acc_out.
- branch  out  1  opcode is BNZ.
- branch_taken  out  1  branch AND acc_nz.
- alu_ctrl  out  2  ALU operation code.
- alu_out  out  8  ALU result.
- acc_out  out  8  accumulator register.
- acc_nz  out  1  acc_out != 0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: on a rising edge with rst_n=0, acc_out <= 0.
- While rst_n=0, reg_we, mem_we, branch and branch_taken are forced to 0. All other outputs stay combinational.
- Sign extension: ext_imm = {3{imm[4]}, imm}, giving a range of -16..15.
- ALU (combinational), A = acc_out, B = reg_rdata, all arithmetic modulo 256, no carry/flag outputs:
  - 00 ADD: A+B.
  - 01 SUB: A-B.
  - 10 NAND: ~(A&B).
  - 11 LINK: pc_addr+1.
- Decode is purely combinational from instr[7:5]. Signals not listed for an opcode are 0, and alu_ctrl defaults to 00.
  - 000 ADD: reg[imm] <= acc + reg[imm]. reg_we=1, alu_ctrl=00, reg_wsel=0.
  - 001 SUB: reg[imm] <= acc - reg[imm]. reg_we=1, alu_ctrl=01.
  - 010 NAND: reg[imm] <= ~(acc & reg[imm]). reg_we=1, alu_ctrl=10.
  - 011 LI: acc <= ext_imm. Accumulator loads next edge.
  - 100 LA: acc <= reg[imm]. Accumulator loads next edge.
  - 101 LW: reg[imm] <= mem[acc]. reg_we=1, reg_wsel=1, mem_sel=1.
  - 110 SW: mem[acc] <= reg[imm]. mem_we=1, mem_sel=1.
  - 111 JAL/BNZ: branch=1 and reg_we=1, alu_ctrl=11, so reg[imm] <= pc+1 always. branch_taken = acc_nz (PC loads reg[imm] externally when taken).
- Accumulator updates only on LI or LA at a rising edge with rst_n=1; otherwise it holds. LA loads reg_rdata as sampled at that edge.
- Latency: controls and alu_out are valid within the same cycle as instr. Accumulator writes are visible the cycle after.
- acc_nz is derived from the registered acc_out, not from the value being loaded.
- Back-to-back LI then ADD uses the new accumulator value in the ADD cycle.
- Unknown/X opcode is not possible (3-bit, fully decoded).

Test Plan:
- Reset: rst_n=0 for 2 edges with instr=8'hFF -> acc_out=0, reg_we=mem_we=branch_taken=0. Release reset -> acc holds 0.
- LI sign-extension:
  - instr=011_01111 -> acc=8'h0F.
  - instr=011_10000 -> acc=8'hF0.
  - Following instr=000_00011 with reg_rdata=8'h11 -> alu_out=8'h01, reg_we=1, reg_addr=3.
- SUB/NAND wrap:
  - acc=3, reg_rdata=5, opcode 001 -> alu_out=8'hFE.
  - acc=8'hF0, reg_rdata=8'h3C, opcode 010 -> alu_out=8'hCF.
- LA / LW / SW:
  - opcode 100, reg_rdata=8'h2A -> acc=8'h2A next cycle.
  - opcode 101 -> reg_we=1, reg_wsel=1, mem_sel=1, mem_we=0.
  - opcode 110 -> mem_we=1, mem_sel=1, reg_we=0.
- Branch:
  - acc=0, instr=111_11110, pc_addr=8'h20 -> alu_out=8'h21, reg_we=1, branch=1, branch_taken=0.
  - Same with acc=1 -> branch_taken=1.
  - pc_addr=8'hFF -> alu_out=8'h00.
- Reset mid-operation: LI 5 then rst_n=0 at the next edge during an LA -> acc=0, not reg_rdata; write enables 0 while low.
